trap_sequencer: RTL and testbench

- Machine-mode trap/return controller that sits directly upstream of the CSR register file and drives its single write port.
- Takes exception flags, interrupt requests and mret from the MEM stage, plus mstatus/mie/read data from the CSR file.
- Sequences the multi-CSR update for trap entry and for mret over several cycles, stalls the pipeline meanwhile, and issues a PC redirect.

---
 rtl/trap_sequencer.sv | 171 +++++++++++++++++
 tb/tb_trap_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / mret sequencer driving the CSR file's single write port.
// Trap entry writes mepc, mcause, mtval and mstatus one per cycle, then redirects; mret is two cycles.
module trap_sequencer #(
  parameter bit         VECTORED_EN = 1'b1,
  parameter logic [1:0] MPP_RESET   = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] pc_mem,
  input  logic [31:0] inst_mem,
  input  logic [31:0] addr_mem,
  input  logic        illegal_inst,
  input  logic        ecall,
  input  logic        l_fault,
  input  logic        s_fault,
  input  logic        mret,
  input  logic        ext_int,
  input  logic [31:0] mstatus,
  input  logic [31:0] mie,
  input  logic [31:0] csr_rdata,
  output logic [11:0] csr_raddr,
  output logic        csr_w,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic [1:0]  csr_wsc_mode,
  output logic        flush,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    IDLE, S_MEPC, S_MCAUSE, S_MTVAL, S_MSTATUS, S_JUMP, R_MSTATUS, R_JUMP
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] epc, cause, tval;

  logic        int_take, trap_take, mret_take;
  logic [31:0] take_cause, take_tval;
  logic [31:0] trap_base, vec_off;

  logic        unused;
  assign unused = ^{mie[31:12], mie[10:0]};

  assign int_take  = inst_valid & ext_int & mstatus[3] & mie[11];
  assign trap_take = int_take | (inst_valid & (illegal_inst | ecall | l_fault | s_fault));
  assign mret_take = inst_valid & mret & ~trap_take;

  // Cause/tval priority: interrupt, illegal, ecall, load fault, store fault.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    take_cause = 32'd0;
    take_tval  = 32'd0;
    if (int_take) begin
      take_cause = 32'h8000_000B;
    end else if (illegal_inst) begin
      take_cause = 32'd2;
      take_tval  = inst_mem;
    end else if (ecall) begin
      take_cause = 32'd11;
    end else if (l_fault) begin
      take_cause = 32'd5;
      take_tval  = addr_mem;
    end else if (s_fault) begin
      take_cause = 32'd7;
      take_tval  = addr_mem;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the trap context is only three words, so it is cleared on reset for clean observability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc   <= 32'd0;
      cause <= 32'd0;
      tval  <= 32'd0;
    end else if (state == IDLE && (trap_take || mret_take)) begin
      epc   <= pc_mem;
      cause <= take_cause;
      tval  <= take_tval;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (trap_take)      state_nxt = S_MEPC;
        else if (mret_take) state_nxt = R_MSTATUS;
      end
      S_MEPC:    state_nxt = S_MCAUSE;
      S_MCAUSE:  state_nxt = S_MTVAL;
      S_MTVAL:   state_nxt = S_MSTATUS;
      S_MSTATUS: state_nxt = S_JUMP;
      S_JUMP:    state_nxt = IDLE;
      R_MSTATUS: state_nxt = R_JUMP;
      R_JUMP:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign trap_base = {csr_rdata[31:2], 2'b00};
  assign vec_off   = {cause[29:0], 2'b00};

  always_comb begin
    csr_raddr      = 12'h000;
    csr_w          = 1'b0;
    csr_waddr      = 12'h000;
    csr_wdata      = 32'd0;
    csr_wsc_mode   = 2'b01;
    flush          = 1'b0;
    busy           = (state != IDLE);
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    case (state)
      IDLE: flush = trap_take | mret_take;
      S_MEPC: begin
        csr_w     = 1'b1;
        csr_waddr = 12'h341;
        csr_wdata = epc;
      end
      S_MCAUSE: begin
        csr_w     = 1'b1;
        csr_waddr = 12'h342;
        csr_wdata = cause;
      end
      S_MTVAL: begin
        csr_w     = 1'b1;
        csr_waddr = 12'h343;
        csr_wdata = tval;
      end
      S_MSTATUS: begin
        csr_w             = 1'b1;
        csr_waddr         = 12'h300;
        csr_wdata         = mstatus;
        csr_wdata[7]      = mstatus[3];
        csr_wdata[3]      = 1'b0;
        csr_wdata[12:11]  = MPP_RESET;
      end
      S_JUMP: begin
        csr_raddr      = 12'h305;
        redirect_valid = 1'b1;
        if (cause[31] && VECTORED_EN && csr_rdata[1:0] == 2'b01)
          redirect_pc = trap_base + vec_off;
        else
          redirect_pc = trap_base;
      end
      R_MSTATUS: begin
        csr_w        = 1'b1;
        csr_waddr    = 12'h300;
        csr_wdata    = mstatus;
        csr_wdata[3] = mstatus[7];
        csr_wdata[7] = 1'b1;
      end
      R_JUMP: begin
        csr_raddr      = 12'h341;
        redirect_valid = 1'b1;
        redirect_pc    = csr_rdata & ~32'd3;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: cycle-by-cycle CSR write, busy/flush and redirect checks.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [31:0] pc_mem, inst_mem, addr_mem;
  logic        illegal_inst, ecall, l_fault, s_fault, mret, ext_int;
  logic [31:0] mstatus, mie, csr_rdata;
  logic [11:0] csr_raddr, csr_waddr;
  logic        csr_w, flush, busy, redirect_valid;
  logic [31:0] csr_wdata, redirect_pc;
  logic [1:0]  csr_wsc_mode;

  logic [31:0] mtvec_val, mepc_val;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  // Tiny CSR file model answering the sequencer's combinational reads.
  always_comb begin
    csr_rdata = 32'd0;
    if (csr_raddr == 12'h305)      csr_rdata = mtvec_val;
    else if (csr_raddr == 12'h341) csr_rdata = mepc_val;
  end

  trap_sequencer dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc_mem(pc_mem),
    .inst_mem(inst_mem), .addr_mem(addr_mem), .illegal_inst(illegal_inst),
    .ecall(ecall), .l_fault(l_fault), .s_fault(s_fault), .mret(mret),
    .ext_int(ext_int), .mstatus(mstatus), .mie(mie), .csr_rdata(csr_rdata),
    .csr_raddr(csr_raddr), .csr_w(csr_w), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .csr_wsc_mode(csr_wsc_mode), .flush(flush),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic clear_flags();
    inst_valid = 0; illegal_inst = 0; ecall = 0; l_fault = 0;
    s_fault = 0; mret = 0; ext_int = 0;
  endtask

  // Checks the cycle that was entered at the last negedge; sampled 1ns later.
  task automatic expect_cyc(input string tag, input logic w, input logic [11:0] waddr,
                            input logic [31:0] wdata, input logic bsy, input logic fl,
                            input logic rv, input logic [31:0] rpc);
    #1;
    check({tag, ".csr_w"}, {31'd0, csr_w}, {31'd0, w});
    check({tag, ".busy"},  {31'd0, busy},  {31'd0, bsy});
    check({tag, ".flush"}, {31'd0, flush}, {31'd0, fl});
    check({tag, ".rv"},    {31'd0, redirect_valid}, {31'd0, rv});
    if (w) begin
      check({tag, ".waddr"}, {20'd0, csr_waddr}, {20'd0, waddr});
      check({tag, ".wdata"}, csr_wdata, wdata);
      check({tag, ".mode"},  {30'd0, csr_wsc_mode}, 32'd1);
    end
    if (rv) check({tag, ".rpc"}, redirect_pc, rpc);
  endtask

  // Caller has already driven the take stimulus at this negedge (cycle T).
  task automatic run_trap(input string tag, input logic [31:0] epc, input logic [31:0] cause,
                          input logic [31:0] tval, input logic [31:0] ms_new,
                          input logic [31:0] rpc);
    expect_cyc({tag, ".T"}, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk); clear_flags();
    expect_cyc({tag, ".mepc"},    1, 12'h341, epc,    1, 0, 0, 0);
    @(negedge clk); expect_cyc({tag, ".mcause"},  1, 12'h342, cause,  1, 0, 0, 0);
    @(negedge clk); expect_cyc({tag, ".mtval"},   1, 12'h343, tval,   1, 0, 0, 0);
    @(negedge clk); expect_cyc({tag, ".mstatus"}, 1, 12'h300, ms_new, 1, 0, 0, 0);
    @(negedge clk); expect_cyc({tag, ".jump"},    0, 0, 0, 1, 0, 1, rpc);
    @(negedge clk); expect_cyc({tag, ".idle"},    0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; clear_flags();
    pc_mem = 0; inst_mem = 0; addr_mem = 0; mstatus = 0; mie = 0;
    mtvec_val = 32'h200; mepc_val = 0;
    #12;
    check("rst.wdata", csr_wdata, 32'd0);
    check("rst.mode", {30'd0, csr_wsc_mode}, 32'd1);
    check("rst.raddr", {20'd0, csr_raddr}, 32'd0);
    check("rst.rpc", redirect_pc, 32'd0);
    check("rst.ctl", {28'd0, csr_w, flush, busy, redirect_valid}, 32'd0);
    @(negedge clk); rst = 0;
    expect_cyc("idle0", 0, 0, 0, 0, 0, 0, 0);

    // Illegal instruction, non-vectored
    @(negedge clk);
    inst_valid = 1; illegal_inst = 1; pc_mem = 32'h100; inst_mem = 32'hFFFF_FFFF;
    mstatus = 32'h88; mtvec_val = 32'h200;
    run_trap("ill", 32'h100, 32'd2, 32'hFFFF_FFFF, 32'h1880, 32'h200);

    // External interrupt, vectored mtvec
    @(negedge clk);
    inst_valid = 1; ext_int = 1; pc_mem = 32'h40; mstatus = 32'h8; mie = 32'h800;
    mtvec_val = 32'h201;
    run_trap("int", 32'h40, 32'h8000_000B, 32'd0, 32'h1880, 32'h22C);

    // Interrupt masked by mstatus.MIE; ecall taken, exception ignores vectoring
    @(negedge clk);
    inst_valid = 1; ext_int = 1; ecall = 1; pc_mem = 32'h80; mstatus = 32'h0;
    run_trap("ecall", 32'h80, 32'd11, 32'd0, 32'h1800, 32'h200);

    // Interrupt masked by mie: no activity
    @(negedge clk);
    inst_valid = 1; ext_int = 1; mstatus = 32'h8; mie = 32'h0;
    expect_cyc("mie0.T", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); clear_flags();
    expect_cyc("mie0.T1", 0, 0, 0, 0, 0, 0, 0);

    // Flags without inst_valid: no take
    @(negedge clk);
    illegal_inst = 1; mret = 1;
    expect_cyc("nv.T", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); clear_flags();
    expect_cyc("nv.T1", 0, 0, 0, 0, 0, 0, 0);

    // Priority: illegal over ecall over load fault
    @(negedge clk);
    inst_valid = 1; illegal_inst = 1; ecall = 1; l_fault = 1;
    pc_mem = 32'h104; inst_mem = 32'h13; addr_mem = 32'h500; mstatus = 32'h0;
    mtvec_val = 32'h200;
    run_trap("prio", 32'h104, 32'd2, 32'h13, 32'h1800, 32'h200);

    // Store fault beats mret
    @(negedge clk);
    inst_valid = 1; s_fault = 1; mret = 1; pc_mem = 32'h108; addr_mem = 32'h600;
    run_trap("sf", 32'h108, 32'd7, 32'h600, 32'h1800, 32'h200);

    // mret
    @(negedge clk);
    inst_valid = 1; mret = 1; pc_mem = 32'h50; mstatus = 32'h1880; mepc_val = 32'h104;
    expect_cyc("mret.T", 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk); clear_flags();
    expect_cyc("mret.ms",   1, 12'h300, 32'h1888, 1, 0, 0, 0);
    @(negedge clk); expect_cyc("mret.jump", 0, 0, 0, 1, 0, 1, 32'h104);
    @(negedge clk); expect_cyc("mret.idle", 0, 0, 0, 0, 0, 0, 0);

    // Reset in S_MCAUSE aborts the sequence
    @(negedge clk);
    inst_valid = 1; ecall = 1; pc_mem = 32'h300; mstatus = 32'h0;
    expect_cyc("ra.T", 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk); clear_flags();
    expect_cyc("ra.mepc",   1, 12'h341, 32'h300, 1, 0, 0, 0);
    @(negedge clk); expect_cyc("ra.mcause", 1, 12'h342, 32'd11, 1, 0, 0, 0);
    #1 rst = 1;
    expect_cyc("ra.rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); expect_cyc("ra.hold", 0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    @(negedge clk); expect_cyc("ra.after", 0, 0, 0, 0, 0, 0, 0);

    // Full trap after reset release
    @(negedge clk);
    inst_valid = 1; l_fault = 1; pc_mem = 32'h400; addr_mem = 32'h1234; mstatus = 32'h8;
    mie = 32'h0;
    run_trap("post", 32'h400, 32'd5, 32'h1234, 32'h1880, 32'h200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
